// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and captured-request layout shared by
// the data-memory unit and its byte-lane aligner.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  // Bytes touched by an access; 0 marks the illegal encoding.
  function automatic int size_bytes(logic [1:0] size);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request/response bundle between core and dmem_ctrl.
// par_flip exists only when DMEM_PARITY_EN is defined.
interface dmem_if #(parameter int ADDR_W = 8);
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
`ifdef DMEM_PARITY_EN
  logic              par_flip;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, par_flip,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, par_flip,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`endif
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian lane steering. Lane i is byte addr+i; loads are
// right-aligned and extended, stores are split into lanes with a byte mask.
module dmem_lane_align import dmem_pkg::*; (
  input  logic [1:0]                size_i,
  input  logic                      sgn_i,
  input  logic [31:0]               wdata_i,
  input  logic [NUM_LANES-1:0][7:0] fetch_i,
  output logic [31:0]               rdata_o,
  output logic [NUM_LANES-1:0][7:0] lanes_o,
  output logic [NUM_LANES-1:0]      bmask_o
);
  always_comb begin
    rdata_o = '0;
    lanes_o = '0;
    bmask_o = '0;
    case (size_i)
      SZ_BYTE: begin
        rdata_o    = {{24{sgn_i & fetch_i[0][7]}}, fetch_i[0]};
        lanes_o[0] = wdata_i[7:0];
        bmask_o    = 4'b0001;
      end
      SZ_HALF: begin
        rdata_o    = {{16{sgn_i & fetch_i[0][7]}}, fetch_i[0], fetch_i[1]};
        lanes_o[0] = wdata_i[15:8];
        lanes_o[1] = wdata_i[7:0];
        bmask_o    = 4'b0011;
      end
      SZ_WORD: begin
        rdata_o = {fetch_i[0], fetch_i[1], fetch_i[2], fetch_i[3]};
        for (int i = 0; i < NUM_LANES; i++) lanes_o[i] = wdata_i[8*(NUM_LANES-1-i) +: 8];
        bmask_o = '1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle big-endian byte store behind a valid/ready handshake.
// Define DMEM_PARITY_EN for per-byte even parity and the par_flip test hook.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0] mem_q [DEPTH];

  req_t                           acc;
  logic [ADDR_W-1:0]              acc_addr;
  logic                           commit, addr_err, par_err;
  int                             nbytes;
  logic [NUM_LANES-1:0][IDX_W-1:0] idx;
  logic [NUM_LANES-1:0][7:0]      fetch, st_lanes;
  logic [NUM_LANES-1:0]           bmask;
  logic [31:0]                    ld_data;

  // ---- FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : fsm_outputs
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  // While idle the live inputs are the access, so WAIT_CYCLES=0 can commit on the accept edge.
  always_comb begin
    acc      = req_q;
    acc_addr = addr_q;
    if (state_q == IDLE) begin
      acc.write = bus.req_write;
      acc.size  = bus.req_size;
      acc.sgn   = bus.req_signed;
      acc.wdata = bus.req_wdata;
      acc_addr  = bus.req_addr;
    end
  end

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && bus.req_valid) begin
      req_d  = acc;
      addr_d = acc_addr;
      cnt_d  = CNT_INIT;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    nbytes   = size_bytes(acc.size);
    addr_err = (nbytes == 0) || ((int'(acc_addr) & (nbytes - 1)) != 0) ||
               (int'(acc_addr) + nbytes > DEPTH);
    for (int i = 0; i < NUM_LANES; i++) begin
      idx[i]   = IDX_W'(int'(acc_addr) + i);
      fetch[i] = mem_q[idx[i]];
    end
  end

  assign commit = !reset && (state_q != RESP) && (state_d == RESP);

  dmem_lane_align u_align (
    .size_i  (acc.size),
    .sgn_i   (acc.sgn),
    .wdata_i (acc.wdata),
    .fetch_i (fetch),
    .rdata_o (ld_data),
    .lanes_o (st_lanes),
    .bmask_o (bmask)
  );

`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH];
  logic flip_q, flip_d, acc_flip;

  assign acc_flip = (state_q == IDLE) ? bus.par_flip : flip_q;
  assign flip_d   = (state_q == IDLE && bus.req_valid) ? acc_flip : flip_q;

  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (bmask[i] && ((^fetch[i]) != par_q[idx[i]])) par_err = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flip_q <= 1'b0;
    else       flip_q <= flip_d;
  end

  always_ff @(posedge clk) begin
    if (commit && acc.write && !addr_err)
      for (int i = 0; i < NUM_LANES; i++)
        if (bmask[i]) par_q[idx[i]] <= (^st_lanes[i]) ^ acc_flip;
  end
`else
  assign par_err = 1'b0;
`endif

  // Response is latched on the entry edge and held until the consumer takes it.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = addr_err || (!acc.write && par_err);
      rdata_d = (acc.write || addr_err || par_err) ? '0 : ld_data;
    end else if (state_q == RESP && bus.resp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && acc.write && !addr_err)
      for (int i = 0; i < NUM_LANES; i++)
        if (bmask[i]) mem_q[idx[i]] <= st_lanes[i];
  end
endmodule
